// File: rtl/pc_fetch_unit.sv
// MIPS IF stage: holds the PC, fetches over a req/ack memory port and hands one
// registered instruction at a time to ID, with delay-slot and exception redirects.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_instr
);

  typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_target;
  logic              pend_valid;
  logic              discard;
  logic              fetch_done;

  assign fetch_done = (state == REQ) && imem_ack && !discard;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (exc_valid) begin
      next_state = REQ;
    end else begin
      case (state)
        IDLE:    next_state = REQ;
        REQ:     if (imem_ack && !discard) next_state = VALID;
        VALID:   if (id_ready) next_state = REQ;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req  = (state == REQ);
    imem_addr = pc;
  end

  // An exception during an outstanding read cannot cancel it, so the in-flight
  // response is marked for discard and the new request follows it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      discard     <= 1'b0;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= '0;
    end else if (exc_valid) begin
      pc         <= exc_target & ALIGN_MASK;
      pend_valid <= 1'b0;
      if_valid   <= 1'b0;
      discard    <= (state == REQ) && !imem_ack;
    end else if (fetch_done) begin
      if_instr   <= imem_rdata;
      if_pc      <= pc;
      if_valid   <= 1'b1;
      pend_valid <= 1'b0;
      // A redirect arriving with this ack means this fetch was the delay slot.
      if (pend_valid)          pc <= pend_target;
      else if (redirect_valid) pc <= redirect_target & ALIGN_MASK;
      else                     pc <= pc + ADDR_W'(4);
    end else begin
      if ((state == REQ) && imem_ack)   discard  <= 1'b0;
      if ((state == VALID) && id_ready) if_valid <= 1'b0;
      if (redirect_valid && !pend_valid) begin
        pend_valid  <= 1'b1;
        pend_target <= redirect_target & ALIGN_MASK;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit: an event-level fetch model predicts
// request addresses and the sequence of instructions presented to ID.
module tb_pc_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        exc_valid = 1'b0;
  logic [31:0] exc_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  pc_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .exc_valid(exc_valid), .exc_target(exc_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t sb[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  // Reference model: next address to be fetched, pending branch target, and
  // whether the outstanding memory response belongs to a flushed stream.
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_pend_t = '0;
  bit          m_pend = 0;
  bit          m_drop = 0;

  bit busy = 0;
  int wait_left = 0;
  bit ack_en = 1;
  int lat_max = 0;
  int p_ready = 100;
  int p_redir = 0;
  int p_exc = 0;
  bit alt_check = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: choose inputs at the falling edge and advance the model for the
  // rising edge that follows.
  task automatic applyStimulus();
    logic        ack_n;
    logic        redir_n;
    logic        exc_n;
    logic [31:0] rt;
    logic [31:0] et;
    @(negedge clk);
    if (imem_req && !m_drop) checkOutput("imem_addr", imem_addr, m_pc);
    ack_n = 1'b0;
    if (imem_req && ack_en) begin
      if (!busy) begin
        busy = 1;
        wait_left = $urandom_range(lat_max, 0);
      end
      if (wait_left == 0) begin
        ack_n = 1'b1;
        busy = 0;
      end else begin
        wait_left--;
      end
    end
    redir_n = ($urandom_range(99, 0) < p_redir);
    exc_n   = ($urandom_range(99, 0) < p_exc);
    rt      = $urandom;
    et      = $urandom;
    id_ready        = ($urandom_range(99, 0) < p_ready);
    imem_ack        = ack_n;
    imem_rdata      = ack_n ? mem_word(imem_addr) : $urandom;
    redirect_valid  = redir_n;
    redirect_target = rt;
    exc_valid       = exc_n;
    exc_target      = et;
    if (exc_n) begin
      m_drop = imem_req && !ack_n;
      m_pc   = et & ~32'd3;
      m_pend = 0;
    end else if (ack_n && m_drop) begin
      m_drop = 0;
      if (redir_n && !m_pend) begin
        m_pend   = 1;
        m_pend_t = rt & ~32'd3;
      end
    end else if (ack_n) begin
      sb.push_back('{m_pc, mem_word(m_pc)});
      if (m_pend) begin
        m_pc   = m_pend_t;
        m_pend = 0;
      end else if (redir_n) begin
        m_pc = rt & ~32'd3;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end else if (redir_n && !m_pend) begin
      m_pend   = 1;
      m_pend_t = rt & ~32'd3;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic drainAndCheck();
    ack_en  = 0;
    p_redir = 0;
    p_exc   = 0;
    runCycles(6);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic resetModel();
    m_pc   = RESET_PC;
    m_pend = 0;
    m_drop = 0;
    busy   = 0;
  endtask

  task automatic quietInputs();
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    exc_valid      = 1'b0;
    id_ready       = 1'b0;
  endtask

  // Monitor: every rising edge of if_valid is a new presentation to ID.
  initial begin
    bit          prev_v = 0;
    bit          alt_armed = 0;
    logic [31:0] last_pc = '0;
    logic [31:0] last_instr = '0;
    item_t       it;
    forever begin
      @(posedge clk);
      #1;
      if (if_valid && !prev_v) begin
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_presentation: got pc %h with nothing expected", if_pc);
        end else begin
          it = sb.pop_front();
          checkOutput("if_pc", if_pc, it.pc);
          checkOutput("if_instr", if_instr, it.instr);
        end
      end else if (if_valid && prev_v) begin
        checkOutput("if_pc_stable", if_pc, last_pc);
        checkOutput("if_instr_stable", if_instr, last_instr);
      end
      if (!alt_check) alt_armed = 0;
      else if (alt_armed) checkOutput("if_valid_alternate", 32'(if_valid), 32'(!prev_v));
      else if (if_valid) alt_armed = 1;
      prev_v     = if_valid;
      last_pc    = if_pc;
      last_instr = if_instr;
    end
  end

  initial begin
    int waited;
    quietInputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_imem_req", 32'(imem_req), 32'd0);
    checkOutput("reset_if_valid", 32'(if_valid), 32'd0);
    checkOutput("reset_if_pc", if_pc, 32'd0);
    checkOutput("reset_if_instr", if_instr, 32'd0);
    checkOutput("reset_imem_addr", imem_addr, RESET_PC);
    rst_n = 1'b1;
    resetModel();

    // Zero-latency acks with ID always ready: sequential fetch every 2nd cycle.
    ack_en = 1; lat_max = 0; p_ready = 100; p_redir = 0; p_exc = 0; alt_check = 1;
    runCycles(14);
    alt_check = 0;

    lat_max = 3; p_ready = 70; p_redir = 15; p_exc = 6;
    runCycles(1500);

    lat_max = 3; p_ready = 30; p_redir = 25; p_exc = 2;
    runCycles(600);
    drainAndCheck();

    // Reset while a request is outstanding.
    waited = 0;
    while (!imem_req && waited < 20) begin
      applyStimulus();
      waited++;
    end
    @(negedge clk);
    checkOutput("imem_req_before_reset", 32'(imem_req), 32'd1);
    quietInputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreq_reset_imem_req", 32'(imem_req), 32'd0);
    checkOutput("midreq_reset_if_valid", 32'(if_valid), 32'd0);
    checkOutput("midreq_reset_pc", imem_addr, RESET_PC);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();

    ack_en = 1; lat_max = 1; p_ready = 80; p_redir = 20; p_exc = 8;
    runCycles(300);
    drainAndCheck();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
